spi_byte_ctrl: RTL and testbench



---
 rtl/spi_byte_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spi_byte_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_ctrl.sv
// spi_byte_ctrl -- byte-level transfer sequencer feeding the ILI9341 SPI shift
// register. Accepts command/data bytes over valid/ready, issues one load per
// byte, one shift strobe per bit, and a CS release load after the last byte.
// SCK is CPOL=0 and rises mid-way through the cycle in which MOSI holds a bit.
//
// Optional feature: define SPI_BYTE_CNT_EN to add o_byte_cnt[15:0], a
// wrapping count of completed bytes (+1 on every o_done).

module spi_byte_ctrl #(
  parameter int DW      = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_dc,
  input  logic          i_last,
  output logic          o_load,
  output logic          o_shift_en,
  output logic [DW-1:0] o_data,
  output logic          o_dc,
  output logic          o_cs,
  output logic          o_sck,
  output logic          o_busy,
  output logic          o_done
`ifdef SPI_BYTE_CNT_EN
  ,
  output logic [15:0]   o_byte_cnt
`endif
);

  localparam int            BW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(CS_GAP - 1);

  // Out-of-range parameters stop elaboration rather than building a broken divider.
  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_byte_ctrl: CLK_DIV must be in 2..255");
  end
  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("spi_byte_ctrl: CS_GAP must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_REL,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          hold_dc_q, hold_dc_d;
  logic          hold_last_q, hold_last_d;
  // Values driven at the most recent load; the shifter-facing outputs hold these.
  logic [DW-1:0] data_q;
  logic          dc_q;
  logic          cs_q;
  logic          sck_q;

  assign o_busy = (state_q != S_IDLE);

  // Next-state, counter and output decode for the transfer sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned -- a missing default would infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    hold_data_d = hold_data_q;
    hold_dc_d   = hold_dc_q;
    hold_last_d = hold_last_q;
    o_ready     = 1'b0;
    o_load      = 1'b0;
    o_shift_en  = 1'b0;
    o_done      = 1'b0;
    o_data      = data_q;
    o_dc        = dc_q;
    o_cs        = cs_q;

    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          hold_data_d = i_data;
          hold_dc_d   = i_dc;
          hold_last_d = i_last;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        o_load    = 1'b1;
        o_data    = hold_data_q;
        o_dc      = hold_dc_q;
        o_cs      = 1'b0;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        o_shift_en = (div_cnt_q == 8'd0);
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            o_done    = 1'b1;
            bit_cnt_d = '0;
            state_d   = hold_last_q ? S_REL : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      // Release load: idle-high MOSI pattern and CS deasserted.
      S_REL: begin
        o_load    = 1'b1;
        o_data    = '1;
        o_dc      = 1'b1;
        o_cs      = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, hold registers and last-driven shifter inputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      hold_data_q <= '0;
      hold_dc_q   <= 1'b0;
      hold_last_q <= 1'b0;
      data_q      <= '1;
      dc_q        <= 1'b1;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_data_q <= hold_data_d;
      hold_dc_q   <= hold_dc_d;
      hold_last_q <= hold_last_d;
      data_q      <= o_data;
      dc_q        <= o_dc;
      cs_q        <= o_cs;
      sck_q       <= o_shift_en;
    end
  end

  // Half-cycle retime of the delayed strobe: SCK rises mid-cycle, centred on
  // the cycle in which the shifter's MOSI carries the bit.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      o_sck <= 1'b0;
    end else begin
      o_sck <= sck_q;
    end
  end

`ifdef SPI_BYTE_CNT_EN
  // Completed-byte counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_byte_cnt <= '0;
    end else if (o_done) begin
      o_byte_cnt <= o_byte_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Testbench for spi_byte_ctrl: two instances (CLK_DIV=4/CS_GAP=2 and
// CLK_DIV=2/CS_GAP=1). The driver pushes expected loads, strobes, done pulses,
// SCK edges and MOSI bits into per-instance queues; a monitor running 2 time
// units after each rising edge compares whatever the DUT presents.

module tb_spi_byte_ctrl;

  localparam int NCYC = 4096;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       dc;
    logic       cs;
  } load_e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic [1:0]      valid_r;
  logic [1:0][7:0] data_r;
  logic [1:0]      dcin_r;
  logic [1:0]      last_r;

  wire [1:0]      ready_w, load_w, shift_w, dc_w, cs_w, sck_w, busy_w, done_w;
  wire [1:0][7:0] data_w;
`ifdef SPI_BYTE_CNT_EN
  wire [1:0][15:0] bc_w;
`endif

  // Scoreboard state
  load_e q_load  [2][$];
  int    q_shift [2][$];
  int    q_done  [2][$];
  bit    q_bit   [2][$];
  bit    exp_sh  [2][NCYC];
  logic [1:0][7:0]  held_data;
  logic [1:0]       held_dc, held_cs;
  logic [1:0][15:0] bcnt_m;
  logic [1:0][7:0]  sh_m;
  logic [1:0]       mosi_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_byte_ctrl #(.DW(8), .CLK_DIV(4), .CS_GAP(2)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (valid_r[0]),
    .o_ready    (ready_w[0]),
    .i_data     (data_r[0]),
    .i_dc       (dcin_r[0]),
    .i_last     (last_r[0]),
    .o_load     (load_w[0]),
    .o_shift_en (shift_w[0]),
    .o_data     (data_w[0]),
    .o_dc       (dc_w[0]),
    .o_cs       (cs_w[0]),
    .o_sck      (sck_w[0]),
    .o_busy     (busy_w[0]),
    .o_done     (done_w[0])
`ifdef SPI_BYTE_CNT_EN
    ,
    .o_byte_cnt (bc_w[0])
`endif
  );

  spi_byte_ctrl #(.DW(8), .CLK_DIV(2), .CS_GAP(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (valid_r[1]),
    .o_ready    (ready_w[1]),
    .i_data     (data_r[1]),
    .i_dc       (dcin_r[1]),
    .i_last     (last_r[1]),
    .o_load     (load_w[1]),
    .o_shift_en (shift_w[1]),
    .o_data     (data_w[1]),
    .o_dc       (dc_w[1]),
    .o_cs       (cs_w[1]),
    .o_sck      (sck_w[1]),
    .o_busy     (busy_w[1]),
    .o_done     (done_w[1])
`ifdef SPI_BYTE_CNT_EN
    ,
    .o_byte_cnt (bc_w[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reset values: ready,load,shift,data[7:0],dc,cs,sck,busy,done = 1,0,0,FF,1,1,0,0,0
  task automatic chk_reset(input int k);
    check($sformatf("u%0d reset outputs", k),
          {16'b0, ready_w[k], load_w[k], shift_w[k], data_w[k], dc_w[k], cs_w[k],
           sck_w[k], busy_w[k], done_w[k]},
          32'h0000_9FF8);
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) begin
      q_load[k].delete();
      q_shift[k].delete();
      q_done[k].delete();
      q_bit[k].delete();
      held_data[k] = 8'hFF;
      held_dc[k]   = 1'b1;
      held_cs[k]   = 1'b1;
      bcnt_m[k]    = 16'd0;
      sh_m[k]      = 8'hFF;
      mosi_m[k]    = 1'b0;
      for (int i = 0; i < NCYC; i++) exp_sh[k][i] = 1'b0;
    end
  endtask

  // Present one byte (called 1 unit after a rising edge), wait for the
  // handshake, check the accept cycle and queue the expected response.
  task automatic send(input int k, input logic [7:0] d, input logic dc,
                      input logic last, input int exp_acc);
    int    n;
    int    div;
    int    s;
    load_e e;
    div = (k == 0) ? 4 : 2;
    valid_r[k] = 1'b1;
    data_r[k]  = d;
    dcin_r[k]  = dc;
    last_r[k]  = last;
    n = 0;
    while (!ready_w[k] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("u%0d accept cycle of 0x%02h", k, d), cyc, exp_acc);
    e.cyc = exp_acc + 1; e.data = d; e.dc = dc; e.cs = 1'b0;
    q_load[k].push_back(e);
    for (int b = 0; b < 8; b++) begin
      s = exp_acc + 2 + div * b;
      q_shift[k].push_back(s);
      if (s < NCYC) exp_sh[k][s] = 1'b1;
      q_bit[k].push_back(d[7-b]);
    end
    q_done[k].push_back(exp_acc + 1 + 8 * div);
    if (last) begin
      e.cyc = exp_acc + 2 + 8 * div; e.data = 8'hFF; e.dc = 1'b1; e.cs = 1'b1;
      q_load[k].push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int k);
    int    c;
    logic  exp_ev;
    logic  exp_sck;
    bit    b;
    load_e e;
    c = cyc;

    exp_ev = (q_load[k].size() != 0) && (q_load[k][0].cyc == c);
    check($sformatf("u%0d load strobe", k), 32'(load_w[k]), 32'(exp_ev));
    if (exp_ev) begin
      e = q_load[k].pop_front();
      if (load_w[k])
        check($sformatf("u%0d load data/dc/cs", k),
              {22'b0, data_w[k], dc_w[k], cs_w[k]}, {22'b0, e.data, e.dc, e.cs});
      held_data[k] = e.data;
      held_dc[k]   = e.dc;
      held_cs[k]   = e.cs;
    end else begin
      check($sformatf("u%0d held data/dc/cs", k),
            {22'b0, data_w[k], dc_w[k], cs_w[k]}, {22'b0, held_data[k], held_dc[k], held_cs[k]});
    end

    exp_ev = (q_shift[k].size() != 0) && (q_shift[k][0] == c);
    check($sformatf("u%0d shift strobe", k), 32'(shift_w[k]), 32'(exp_ev));
    if (exp_ev) void'(q_shift[k].pop_front());

    exp_ev = (q_done[k].size() != 0) && (q_done[k][0] == c);
    check($sformatf("u%0d done pulse", k), 32'(done_w[k]), 32'(exp_ev));
    if (exp_ev) begin
      void'(q_done[k].pop_front());
      bcnt_m[k] = bcnt_m[k] + 16'd1;
    end

    // SCK is high across this sample point iff a strobe happened two cycles ago.
    exp_sck = (c >= 2 && c - 2 < NCYC) ? exp_sh[k][c-2] : 1'b0;
    check($sformatf("u%0d sck level", k), 32'(sck_w[k]), 32'(exp_sck));
    if (exp_sck && q_bit[k].size() != 0) begin
      b = q_bit[k].pop_front();
      check($sformatf("u%0d mosi at sck rise", k), 32'(mosi_m[k]), 32'(b));
    end

    // Model of the downstream shifter: MSB out on each strobe.
    if (load_w[k]) begin
      sh_m[k] = data_w[k];
    end else if (shift_w[k]) begin
      mosi_m[k] = sh_m[k][7];
      sh_m[k]   = {sh_m[k][6:0], 1'b0};
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    valid_r = '0;
    data_r  = '0;
    dcin_r  = '0;
    last_r  = '0;
    flush();

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single last byte 0xA5, then a second last byte held ready through the gap
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b1, t0);
    send(0, 8'h3C, 1'b1, 1'b1, t0 + 37);
    valid_r[0] = 1'b0;
    repeat (45) @(posedge clk);
    #1;

    // Back-to-back non-last bytes keep CS low; one release at the end
    t0 = cyc;
    send(0, 8'h2A, 1'b0, 1'b0, t0);
    send(0, 8'h00, 1'b1, 1'b0, t0 + 34);
    send(0, 8'h10, 1'b1, 1'b1, t0 + 68);
    valid_r[0] = 1'b0;
    repeat (45) @(posedge clk);
    #1;

    // CLK_DIV=2, CS_GAP=1 instance
    t0 = cyc;
    send(1, 8'hC3, 1'b0, 1'b1, t0);
    send(1, 8'h5A, 1'b1, 1'b0, t0 + 20);
    send(1, 8'h81, 1'b0, 1'b1, t0 + 38);
    valid_r[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Reset in the middle of SHIFT: immediate abort, no release load
    t0 = cyc;
    send(0, 8'hF0, 1'b1, 1'b1, t0);
    valid_r[0] = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    flush();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("u0 ready after reset release", 32'(ready_w[0]), 32'd1);

    // Recovery after reset
    t0 = cyc;
    send(0, 8'h96, 1'b0, 1'b1, t0);
    valid_r[0] = 1'b0;
    repeat (45) @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d pending expectations", k),
            q_load[k].size() + q_shift[k].size() + q_done[k].size() + q_bit[k].size(), 0);
`ifdef SPI_BYTE_CNT_EN
      check($sformatf("u%0d byte count", k), {16'b0, bc_w[k]}, {16'b0, bcnt_m[k]});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
